// File: rtl/mem_wb_datapath.sv
// MEM-stage back end: big-endian byte-addressable data memory (word/half/byte
// access) feeding the MEM/WB pipeline register handed to the write-back stage.
module mem_wb_datapath #(
   parameter int ADDR_BITS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  load_mode,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   input  logic [4:0]  wb_dest_in,
   output logic [31:0] mem_data,
   output logic [31:0] read_data_out,
   output logic [31:0] address_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic [4:0]  wb_dest_out
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [7:0]           mem_q [0:DEPTH-1];

   logic [ADDR_BITS-1:0] addr_s;
   logic [ADDR_BITS-1:0] w0_s, w1_s, w2_s, w3_s;
   logic [ADDR_BITS-1:0] h0_s, h1_s;
   logic [7:0]           b0_s, b1_s, b2_s, b3_s;
   logic [7:0]           byte_s;
   logic [15:0]          half_s;
   logic [31:0]          mem_data_s;

   logic [31:0]          read_data_d, read_data_q;
   logic [31:0]          address_d, address_q;
   logic                 reg_write_d, reg_write_q;
   logic                 mem_to_reg_d, mem_to_reg_q;
   logic [4:0]           wb_dest_d, wb_dest_q;

   // Upper address bits are not decoded, so accesses wrap modulo the depth.
   assign addr_s = address[ADDR_BITS-1:0];
   assign w0_s   = {addr_s[ADDR_BITS-1:2], 2'b00};
   assign w1_s   = {addr_s[ADDR_BITS-1:2], 2'b01};
   assign w2_s   = {addr_s[ADDR_BITS-1:2], 2'b10};
   assign w3_s   = {addr_s[ADDR_BITS-1:2], 2'b11};
   assign h0_s   = {addr_s[ADDR_BITS-1:1], 1'b0};
   assign h1_s   = {addr_s[ADDR_BITS-1:1], 1'b1};

   // Combinational load path: select, align and extend the addressed bytes.
   always_comb begin
      b0_s       = mem_q[w0_s];
      b1_s       = mem_q[w1_s];
      b2_s       = mem_q[w2_s];
      b3_s       = mem_q[w3_s];
      byte_s     = mem_q[addr_s];
      half_s     = 16'h0000;
      mem_data_s = 32'h0000_0000;
      if (addr_s[1]) begin
         half_s = {b2_s, b3_s};
      end else begin
         half_s = {b0_s, b1_s};
      end
      if (mem_read) begin
         case (load_mode)
            2'b00:   mem_data_s = {b0_s, b1_s, b2_s, b3_s};
            2'b01:   mem_data_s = {{16{half_s[15]}}, half_s};
            2'b10:   mem_data_s = {{24{byte_s[7]}}, byte_s};
            2'b11:   mem_data_s = {24'h00_0000, byte_s};
            default: mem_data_s = 32'h0000_0000;
         endcase
      end else begin
         mem_data_s = 32'h0000_0000;
      end
   end

   assign mem_data = mem_data_s;

   // Store path: memory is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (mem_write) begin
         case (load_mode)
            2'b00: begin
               mem_q[w0_s] <= write_data[31:24];
               mem_q[w1_s] <= write_data[23:16];
               mem_q[w2_s] <= write_data[15:8];
               mem_q[w3_s] <= write_data[7:0];
            end
            2'b01: begin
               mem_q[h0_s] <= write_data[15:8];
               mem_q[h1_s] <= write_data[7:0];
            end
            default: mem_q[addr_s] <= write_data[7:0];
         endcase
      end
   end

   // Next-state of the MEM/WB register: it loads unconditionally every cycle.
   always_comb begin
      read_data_d  = mem_data_s;
      address_d    = address;
      reg_write_d  = reg_write_in;
      mem_to_reg_d = mem_to_reg_in;
      wb_dest_d    = wb_dest_in;
   end

   // MEM/WB pipeline register; reset clears reg_write so no stray RF write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data_q  <= 32'h0000_0000;
         address_q    <= 32'h0000_0000;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         wb_dest_q    <= 5'd0;
      end else begin
         read_data_q  <= read_data_d;
         address_q    <= address_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         wb_dest_q    <= wb_dest_d;
      end
   end

   assign read_data_out  = read_data_q;
   assign address_out    = address_q;
   assign reg_write_out  = reg_write_q;
   assign mem_to_reg_out = mem_to_reg_q;
   assign wb_dest_out    = wb_dest_q;

endmodule

// File: tb/tb_mem_wb_datapath.sv
// Directed scoreboard bench for mem_wb_datapath: expected MEM/WB contents are
// queued when a step is driven and checked one edge later.
module tb_mem_wb_datapath;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [1:0]  load_mode;
   logic [31:0] address, write_data;
   logic        reg_write_in, mem_to_reg_in;
   logic [4:0]  wb_dest_in;
   logic [31:0] mem_data, read_data_out, address_out;
   logic        reg_write_out, mem_to_reg_out;
   logic [4:0]  wb_dest_out;

   typedef struct packed {
      logic [31:0] rd;
      logic [31:0] addr;
      logic        rw;
      logic        m2r;
      logic [4:0]  dest;
   } exp_t;

   exp_t sb_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   mem_wb_datapath #(.ADDR_BITS(10)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .load_mode(load_mode), .address(address), .write_data(write_data),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .wb_dest_in(wb_dest_in), .mem_data(mem_data),
      .read_data_out(read_data_out), .address_out(address_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
      .wb_dest_out(wb_dest_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_regs_zero(input string tag);
      check({tag, ".read_data_out"}, read_data_out, 32'h0);
      check({tag, ".address_out"}, address_out, 32'h0);
      check({tag, ".reg_write_out"}, {31'd0, reg_write_out}, 32'h0);
      check({tag, ".mem_to_reg_out"}, {31'd0, mem_to_reg_out}, 32'h0);
      check({tag, ".wb_dest_out"}, {27'd0, wb_dest_out}, 32'h0);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      compared++;
      assert (sb_q.size() > 0) else begin
         mismatched++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, ".read_data_out"}, read_data_out, e.rd);
         check({tag, ".address_out"}, address_out, e.addr);
         check({tag, ".reg_write_out"}, {31'd0, reg_write_out}, {31'd0, e.rw});
         check({tag, ".mem_to_reg_out"}, {31'd0, mem_to_reg_out}, {31'd0, e.m2r});
         check({tag, ".wb_dest_out"}, {27'd0, wb_dest_out}, {27'd0, e.dest});
      end
   endtask

   // Called at posedge+1: drive, check mem_data, queue expectation, check after edge.
   task automatic step(input string tag, input logic mr, input logic mw,
                       input logic [1:0] mode, input logic [31:0] a,
                       input logic [31:0] wd, input logic rw, input logic m2r,
                       input logic [4:0] dst, input logic [31:0] exp_md);
      exp_t e;
      mem_read = mr; mem_write = mw; load_mode = mode; address = a;
      write_data = wd; reg_write_in = rw; mem_to_reg_in = m2r; wb_dest_in = dst;
      #1;
      check({tag, ".mem_data"}, mem_data, exp_md);
      e.rd = exp_md; e.addr = a; e.rw = rw; e.m2r = m2r; e.dest = dst;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      pop_check(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      mem_read = 1'b1; mem_write = 1'b0; load_mode = 2'b00;
      address = 32'h0000_0ABC; write_data = 32'h5555_5555;
      reg_write_in = 1'b1; mem_to_reg_in = 1'b1; wb_dest_in = 5'd31;

      // Held in reset across clock edges with nonzero inputs.
      @(posedge clk);
      @(posedge clk);
      #1;
      check_regs_zero("reset_hold");
      rst_n = 1'b1;

      step("sw_10",      1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 5'd3, 32'h0);
      step("lw_10",      1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 1'b1, 5'd4, 32'hDEADBEEF);
      step("lh_10",      1'b1, 1'b0, 2'b01, 32'h10, 32'h0, 1'b1, 1'b1, 5'd5, 32'hFFFFDEAD);
      step("lh_12",      1'b1, 1'b0, 2'b01, 32'h12, 32'h0, 1'b1, 1'b1, 5'd6, 32'hFFFFBEEF);
      step("lb_13",      1'b1, 1'b0, 2'b10, 32'h13, 32'h0, 1'b1, 1'b1, 5'd7, 32'hFFFFFFEF);
      step("lbu_13",     1'b1, 1'b0, 2'b11, 32'h13, 32'h0, 1'b1, 1'b1, 5'd8, 32'h000000EF);
      step("lb_11",      1'b1, 1'b0, 2'b10, 32'h11, 32'h0, 1'b1, 1'b1, 5'd10, 32'hFFFFFFAD);
      step("sb_11",      1'b0, 1'b1, 2'b10, 32'h11, 32'h12345677, 1'b0, 1'b0, 5'd0, 32'h0);
      step("lw_after_sb",1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 1'b1, 5'd11, 32'hDE77BEEF);
      step("lb_11_pos",  1'b1, 1'b0, 2'b10, 32'h11, 32'h0, 1'b1, 1'b1, 5'd12, 32'h00000077);
      step("sh_12",      1'b0, 1'b1, 2'b01, 32'h12, 32'h00001234, 1'b0, 1'b0, 5'd0, 32'h0);
      step("lw_after_sh",1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 1'b1, 5'd13, 32'hDE771234);
      step("lh_12_pos",  1'b1, 1'b0, 2'b01, 32'h12, 32'h0, 1'b1, 1'b1, 5'd14, 32'h00001234);
      step("lh_10_neg",  1'b1, 1'b0, 2'b01, 32'h10, 32'h0, 1'b1, 1'b1, 5'd15, 32'hFFFFDE77);
      step("passthru",   1'b0, 1'b0, 2'b00, 32'h410, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0);
      step("lw_wrap",    1'b1, 1'b0, 2'b00, 32'h410, 32'h0, 1'b1, 1'b1, 5'd16, 32'hDE771234);
      step("sw_20",      1'b0, 1'b1, 2'b00, 32'h20, 32'hAAAAAAAA, 1'b0, 1'b0, 5'd0, 32'h0);
      step("rw_same",    1'b1, 1'b1, 2'b00, 32'h20, 32'h11111111, 1'b1, 1'b1, 5'd17, 32'hAAAAAAAA);
      step("lw_20_new",  1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 1'b1, 1'b1, 5'd18, 32'h11111111);

      // Asynchronous reset mid-cycle, no clock edge in between.
      rst_n = 1'b0;
      #1;
      check_regs_zero("async_reset");

      // Store on an edge while in reset must still commit; mem_data stays live.
      mem_read = 1'b1; mem_write = 1'b1; load_mode = 2'b11; address = 32'h21;
      write_data = 32'h000000C3; reg_write_in = 1'b1; mem_to_reg_in = 1'b1; wb_dest_in = 5'd19;
      #1;
      check("reset_lbu_21.mem_data", mem_data, 32'h00000011);
      @(posedge clk);
      #1;
      check_regs_zero("reset_edge");
      rst_n = 1'b1;

      step("lw_20_rst",  1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 1'b1, 1'b1, 5'd20, 32'h11C31111);
      step("lw_10_rst",  1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, 1'b1, 5'd21, 32'hDE771234);

      compared++;
      assert (sb_q.size() == 0) else begin
         mismatched++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
